// File: rtl/micro_pkg.sv
// Shared definitions for the micro-sequencer datapath blocks.
// Mode encodings for the select/arbitration mux.
package micro_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Scans req starting at ptr, wrapping past NCH-1 back to 0.
module rr_pick #(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);
    logic [2*NCH-1:0] w_dbl;
    logic [NCH-1:0]   w_rot;

    // Doubling the vector turns the wrap-around into a plain shift.
    assign w_dbl = {req, req};
    assign w_rot = NCH'(w_dbl >> ptr);

    always_comb begin
        int s;
        s       = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                s = int'(ptr) + k;
                if (s >= NCH) begin
                    s = s - NCH;
                end
                gnt     = '0;
                gnt[s]  = 1'b1;
                gnt_idx = SELW'(s);
            end
        end
    end
endmodule

// File: rtl/sel_arb_mux.sv
// NCH-way valid/ready merge into one registered output channel,
// steered by ctrl (fixed mode) or a round-robin pointer.
module sel_arb_mux
    import micro_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      ctrl,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_can_load;
    logic [NCH-1:0]   w_fix_gnt;
    logic [NCH-1:0]   w_rr_gnt;
    logic [SELW-1:0]  w_rr_idx;
    logic [NCH-1:0]   w_gnt;
    logic [SELW-1:0]  w_gidx;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_data;
    logic [SELW-1:0]  w_ptr_nxt;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx)
    );

    assign w_can_load = !r_out_valid || out_ready;

    // Out-of-range ctrl (non power-of-two NCH) matches no channel.
    always_comb begin
        w_fix_gnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ctrl == SELW'(i)) begin
                w_fix_gnt[i] = in_valid[i];
            end
        end
    end

    assign w_gnt  = (mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
    assign w_gidx = (mode == MODE_RR) ? w_rr_idx : ctrl;
    assign w_any  = |w_gnt;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == SELW'(NCH - 1)) ? '0
                                                  : w_gidx + SELW'(1);

    assign in_ready = w_gnt & {NCH{w_can_load & rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_can_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_sel_data;
                r_out_ch   <= w_gidx;
                if (mode == MODE_RR) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
endmodule
